// File: rtl/cse_bubble_pkg.sv
// Shared definitions for the fetch stage: branch-unit instruction IDs and fetch FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cse_bubble_pkg;

  // Conditional branches: taken when the branch unit output is non-zero.
  localparam logic [31:0] ID_BEQ  = 32'd15;
  localparam logic [31:0] ID_BNE  = 32'd16;
  localparam logic [31:0] ID_BGT  = 32'd17;
  localparam logic [31:0] ID_BGTE = 32'd18;
  localparam logic [31:0] ID_BLE  = 32'd19;
  localparam logic [31:0] ID_BLEQ = 32'd20;
  // Unconditional jumps: branch unit output is the absolute target.
  localparam logic [31:0] ID_J    = 32'd21;
  localparam logic [31:0] ID_JR   = 32'd22;
  localparam logic [31:0] ID_JAL  = 32'd23;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,  // request outstanding (or about to be issued)
    ST_PRESENT = 2'd1,  // holding an instruction for decode
    ST_HALT    = 2'd2   // stopped by the branch unit warning; exit only via reset
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage buses: instruction memory, decode output, branch result, link write.
// Latency: n/a (wiring only).
// Backpressure: imem uses req/ack, decode uses valid/ready; branch and link are unthrottled pulses.
// Ports: master = fetch_unit side, slave = memory/decode/branch environment side.
interface fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  logic              if_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] if_pc;
  logic [31:0]       if_ir;

  logic              br_valid;
  logic [31:0]       br_id;
  logic [ADDR_W-1:0] br_pc;
  logic [31:0]       br_out;
  logic              br_warn;

  logic              lnk_valid;
  logic [ADDR_W-1:0] lnk_addr;
  logic              halted;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_ir, lnk_valid, lnk_addr, halted,
    input  imem_ack, imem_rdata, if_ready, br_valid, br_id, br_pc, br_out, br_warn
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_ir, lnk_valid, lnk_addr, halted,
    output imem_ack, imem_rdata, if_ready, br_valid, br_id, br_pc, br_out, br_warn
  );
endinterface

// File: rtl/fetch_unit_branch_resolve.sv
// Decodes a resolved branch-unit result into taken / target / link-write.
// Latency: combinational.
// Backpressure: none.
// Ports: i_id, i_pc, i_out in; o_taken, o_target, o_is_link out.
module branch_resolve
  import cse_bubble_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [31:0]       i_id,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [31:0]       i_out,
  output logic              o_taken,
  output logic [ADDR_W-1:0] o_target,
  output logic              o_is_link
);

  always_comb begin
    o_taken   = 1'b0;
    o_target  = ADDR_W'(i_out);
    o_is_link = 1'b0;
    if (i_id >= ID_BEQ && i_id <= ID_BLEQ) begin
      // PC-relative from the following instruction; wraps silently.
      o_taken  = (i_out != 32'd0);
      o_target = i_pc + ADDR_W'(1) + ADDR_W'(i_out);
    end else if (i_id >= ID_J && i_id <= ID_JAL) begin
      o_taken   = 1'b1;
      o_is_link = (i_id == ID_JAL);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC sequencer: fetches words over req/ack, presents {pc, ir} to decode, redirects on resolved branches.
// Latency: ack edge -> if_valid next cycle; accept edge -> next imem_req next cycle; redirect -> new address next cycle.
// Backpressure: holds if_valid/if_pc/if_ir stable while if_ready is low; never issues a fetch while presenting.
// Ports: clk, reset (sync, active-low), bus (fetch_unit_if.master).
module fetch_unit
  import cse_bubble_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_drop;
  logic              r_imem_req;
  logic [ADDR_W-1:0] r_imem_addr;
  logic              r_if_valid;
  logic [ADDR_W-1:0] r_if_pc;
  logic [31:0]       r_if_ir;
  logic              r_lnk_valid;
  logic [ADDR_W-1:0] r_lnk_addr;
  logic              r_halted;

  logic              w_taken;
  logic [ADDR_W-1:0] w_target;
  logic              w_is_link;
  logic              w_active;
  logic              w_redirect;
  logic              w_warn;

  branch_resolve #(.ADDR_W(ADDR_W)) u_resolve (
    .i_id      (bus.br_id),
    .i_pc      (bus.br_pc),
    .i_out     (bus.br_out),
    .o_taken   (w_taken),
    .o_target  (w_target),
    .o_is_link (w_is_link)
  );

  // Once halted, branch results are ignored entirely.
  assign w_active   = (r_state != ST_HALT);
  assign w_redirect = bus.br_valid & ~bus.br_warn & w_taken & w_active;
  assign w_warn     = bus.br_valid & bus.br_warn & w_active;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC;
      r_drop      <= 1'b0;
      r_imem_req  <= 1'b0;
      r_imem_addr <= '0;
      r_if_valid  <= 1'b0;
      r_if_pc     <= '0;
      r_if_ir     <= '0;
      r_lnk_valid <= 1'b0;
      r_lnk_addr  <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_lnk_valid <= bus.br_valid & ~bus.br_warn & w_is_link & w_active;
      if (bus.br_valid & ~bus.br_warn & w_is_link & w_active) begin
        r_lnk_addr <= bus.br_pc + ADDR_W'(1);
      end

      if (w_warn) begin
        // An outstanding request must still complete; its data is thrown away.
        r_state    <= ST_HALT;
        r_halted   <= 1'b1;
        r_if_valid <= 1'b0;
        r_imem_req <= r_imem_req & ~bus.imem_ack;
      end else begin
        case (r_state)
          ST_FETCH: begin
            if (!r_imem_req) begin
              // Only reached straight out of reset.
              r_imem_req  <= 1'b1;
              r_imem_addr <= w_redirect ? w_target : r_pc;
              if (w_redirect) r_pc <= w_target;
            end else if (bus.imem_ack) begin
              if (r_drop || w_redirect) begin
                // Wrong-path data: discard and re-request from the live pc.
                r_drop      <= 1'b0;
                r_imem_addr <= w_redirect ? w_target : r_pc;
                if (w_redirect) r_pc <= w_target;
              end else begin
                r_if_ir    <= bus.imem_rdata;
                r_if_pc    <= r_imem_addr;
                r_pc       <= r_pc + ADDR_W'(1);
                r_imem_req <= 1'b0;
                r_if_valid <= 1'b1;
                r_state    <= ST_PRESENT;
              end
            end else if (w_redirect) begin
              // Address must stay stable until ack; remember to drop that data.
              r_pc   <= w_target;
              r_drop <= 1'b1;
            end
          end

          ST_PRESENT: begin
            if (w_redirect) begin
              // Redirect beats a simultaneous accept: the presented instruction is killed.
              r_if_valid  <= 1'b0;
              r_pc        <= w_target;
              r_imem_req  <= 1'b1;
              r_imem_addr <= w_target;
              r_state     <= ST_FETCH;
            end else if (bus.if_ready) begin
              r_if_valid  <= 1'b0;
              r_imem_req  <= 1'b1;
              r_imem_addr <= r_pc;
              r_state     <= ST_FETCH;
            end
          end

          ST_HALT: begin
            if (bus.imem_ack) r_imem_req <= 1'b0;
          end

          default: r_state <= ST_FETCH;
        endcase
      end
    end
  end

  assign bus.imem_req  = r_imem_req;
  assign bus.imem_addr = r_imem_addr;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_pc     = r_if_pc;
  assign bus.if_ir     = r_if_ir;
  assign bus.lnk_valid = r_lnk_valid;
  assign bus.lnk_addr  = r_lnk_addr;
  assign bus.halted    = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with expected fetch addresses and decode outputs queued as stimulus is applied.
// Latency: n/a.
// Backpressure: decode stall exercised via if_ready.
module tb_fetch_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_ir_q[$];

  fetch_unit_if #(.ADDR_W(32)) bus ();

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hA5A5_0000 + a * 32'd3 + 32'd7;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, bus.imem_req, 64'd1);
  endtask

  task automatic expect_fetch(input string tag);
    logic [31:0] e;
    e = exp_addr_q.pop_front();
    check({tag, "_addr"}, bus.imem_addr, e);
  endtask

  task automatic expect_present(input string tag);
    logic [31:0] p;
    logic [31:0] w;
    p = exp_pc_q.pop_front();
    w = exp_ir_q.pop_front();
    check({tag, "_valid"}, bus.if_valid, 64'd1);
    check({tag, "_pc"}, bus.if_pc, p);
    check({tag, "_ir"}, bus.if_ir, w);
  endtask

  task automatic push_present(input logic [31:0] a);
    exp_pc_q.push_back(a);
    exp_ir_q.push_back(word_of(a));
  endtask

  // Holds the current request for lat cycles, then acks with the model word.
  task automatic mem_ack(input int lat, input string tag);
    logic [31:0] a;
    a = bus.imem_addr;
    repeat (lat) begin
      tick();
      check({tag, "_stable"}, bus.imem_addr, a);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word_of(a);
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
  endtask

  task automatic branch(input logic [31:0] id, input logic [31:0] pc, input logic [31:0] out, input logic warn);
    bus.br_valid = 1'b1;
    bus.br_id    = id;
    bus.br_pc    = pc;
    bus.br_out   = out;
    bus.br_warn  = warn;
    tick();
    bus.br_valid = 1'b0;
    bus.br_warn  = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset          = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.if_ready   = 1'b0;
    bus.br_valid   = 1'b0;
    bus.br_id      = '0;
    bus.br_pc      = '0;
    bus.br_out     = '0;
    bus.br_warn    = 1'b0;
    repeat (3) tick();

    check("rst_req", bus.imem_req, 64'd0);
    check("rst_valid", bus.if_valid, 64'd0);
    check("rst_pc", bus.if_pc, 64'd0);
    check("rst_ir", bus.if_ir, 64'd0);
    check("rst_lnk", bus.lnk_valid, 64'd0);
    check("rst_halted", bus.halted, 64'd0);

    reset = 1'b1;
    tick();
    check("req_rise", bus.imem_req, 64'd1);

    // Sequential fetch with decode always ready.
    bus.if_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_addr_q.push_back(32'(i));
      push_present(32'(i));
      wait_req("seq");
      expect_fetch("seq");
      mem_ack(0, "seq");
      expect_present("seq");
      tick();
    end

    // Taken bne in PRESENT with if_ready high: instruction killed, target 5+1+2.
    exp_addr_q.push_back(32'd5);
    push_present(32'd5);
    wait_req("p5");
    expect_fetch("p5");
    mem_ack(1, "p5");
    expect_present("p5");
    exp_addr_q.push_back(32'd8);
    branch(32'd16, 32'd5, 32'd2, 1'b0);
    check("kill_valid", bus.if_valid, 64'd0);
    wait_req("bne");
    expect_fetch("bne");
    check("bne_lnk", bus.lnk_valid, 64'd0);

    push_present(32'd8);
    mem_ack(0, "f8");
    expect_present("f8");
    tick();

    // Held request at 9 with jump arriving mid-wait; ack data must be dropped.
    exp_addr_q.push_back(32'd9);
    wait_req("h9");
    expect_fetch("h9");
    tick();
    branch(32'd21, 32'd0, 32'd100, 1'b0);
    check("held_addr", bus.imem_addr, 64'd9);
    check("held_req", bus.imem_req, 64'd1);
    tick();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word_of(32'd9);
    tick();
    bus.imem_ack   = 1'b0;
    check("drop_valid", bus.if_valid, 64'd0);
    exp_addr_q.push_back(32'd100);
    wait_req("j100");
    expect_fetch("j100");

    push_present(32'd100);
    mem_ack(2, "f100");
    expect_present("f100");
    tick();

    // jal from PRESENT with decode stalled.
    exp_addr_q.push_back(32'd101);
    wait_req("f101");
    expect_fetch("f101");
    bus.if_ready = 1'b0;
    push_present(32'd101);
    mem_ack(0, "f101");
    expect_present("f101");
    exp_addr_q.push_back(32'd100);
    branch(32'd23, 32'd40, 32'd100, 1'b0);
    check("jal_lnk", bus.lnk_valid, 64'd1);
    check("jal_lnk_addr", bus.lnk_addr, 64'd41);
    check("jal_kill", bus.if_valid, 64'd0);
    wait_req("jal");
    expect_fetch("jal");
    tick();
    check("jal_lnk_end", bus.lnk_valid, 64'd0);

    // beq with zero output: not taken, held fetch data must be kept.
    branch(32'd15, 32'd100, 32'd0, 1'b0);
    check("bnt_addr", bus.imem_addr, 64'd100);
    push_present(32'd100);
    mem_ack(0, "bnt");
    expect_present("bnt");

    // Non-branch ID has no effect.
    branch(32'd3, 32'd0, 32'd50, 1'b0);
    check("nonbr_valid", bus.if_valid, 64'd1);

    // Decode stall: outputs hold and no fetch is issued.
    repeat (5) begin
      tick();
      check("stall_valid", bus.if_valid, 64'd1);
      check("stall_pc", bus.if_pc, 64'd100);
      check("stall_ir", bus.if_ir, word_of(32'd100));
      check("stall_req", bus.imem_req, 64'd0);
    end
    bus.if_ready = 1'b1;
    tick();
    exp_addr_q.push_back(32'd101);
    wait_req("post_stall");
    expect_fetch("post_stall");

    // Warning with request outstanding: ack consumed, then halted for good.
    branch(32'd21, 32'd0, 32'd7, 1'b1);
    check("warn_halted", bus.halted, 64'd1);
    check("warn_req_held", bus.imem_req, 64'd1);
    check("warn_addr", bus.imem_addr, 64'd101);
    check("warn_lnk", bus.lnk_valid, 64'd0);
    mem_ack(0, "warn");
    check("halt_req", bus.imem_req, 64'd0);
    check("halt_valid", bus.if_valid, 64'd0);
    repeat (5) begin
      tick();
      check("halt_idle_req", bus.imem_req, 64'd0);
      check("halt_stay", bus.halted, 64'd1);
    end

    // Reset out of HALT; a late ack while req is low is ignored.
    reset = 1'b0;
    tick();
    check("rst2_halted", bus.halted, 64'd0);
    check("rst2_req", bus.imem_req, 64'd0);
    check("rst2_valid", bus.if_valid, 64'd0);
    check("rst2_pc", bus.if_pc, 64'd0);
    bus.imem_ack = 1'b1;
    reset = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    check("late_ack_valid", bus.if_valid, 64'd0);
    exp_addr_q.push_back(32'd0);
    wait_req("resume");
    expect_fetch("resume");
    push_present(32'd0);
    mem_ack(0, "resume");
    expect_present("resume");

    // bgt target wraps past the top of the address space.
    exp_addr_q.push_back(32'd5);
    branch(32'd17, 32'hFFFF_FFFF, 32'd5, 1'b0);
    check("wrap_kill", bus.if_valid, 64'd0);
    wait_req("wrap");
    expect_fetch("wrap");

    // jr while fetch held, ack arrives on the very next cycle.
    branch(32'd22, 32'd0, 32'd200, 1'b0);
    mem_ack(0, "jr");
    check("jr_drop", bus.if_valid, 64'd0);
    exp_addr_q.push_back(32'd200);
    wait_req("jr");
    expect_fetch("jr");

    check("sb_addr_empty", 64'(exp_addr_q.size()), 64'd0);
    check("sb_pc_empty", 64'(exp_pc_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and PC sequencing stage feeding the decode/branch path. It holds the program counter and fetches words from instruction memory over a req/ack handshake. It presents `{pc, ir}` to decode under valid/ready and consumes the branch unit's resolved result (instruction ID, `out`, `warn_signal`) to redirect the PC, squash wrong-path fetches and emit the `jal` link value.

## Interface
- `ADDR_W`, 32, width of PC and instruction-memory address (word-addressed)
- `RESET_PC`, 0, PC loaded on reset
- `clk` input 1: single clock, all state on rising edge
- `reset` input 1: synchronous, active-low; sampled only at `clk` rising edge
- `imem_req` output 1: fetch request
- `imem_addr` output ADDR_W: fetch address, stable while `imem_req` is high and `imem_ack` is low
- `imem_ack` input 1: memory accepts and returns data this cycle
- `imem_rdata` input 32: instruction word, valid when `imem_ack` is high
- `if_valid` output 1: `if_pc`/`if_ir` valid to decode
- `if_ready` input 1: decode accepts this cycle
- `if_pc` output ADDR_W: PC of the presented instruction
- `if_ir` output 32: presented instruction
- `br_valid` input 1: branch unit result valid (one cycle per resolved instruction)
- `br_id` input 32: decoded instruction ID
- `br_pc` input ADDR_W: PC of the resolving instruction
- `br_out` input 32: branch unit output (offset or absolute target)
- `br_warn` input 1: branch unit `warn_signal`
- `lnk_valid` output 1: one-cycle pulse, `jal` link write
- `lnk_addr` output ADDR_W: `br_pc + 1`
- `halted` output 1: block is in HALT

## Operation
- States: FETCH (request outstanding), PRESENT (holding instruction for decode), HALT.
- Redirect decode:
  - IDs 15–20 (beq, bne, bgt, bgte, ble, bleq) are taken iff `br_out != 0`; target = `br_pc + 1 + br_out`, computed mod 2^ADDR_W and wrapping silently.
  - IDs 21–23 (j, jr, jal) are always taken; target = `br_out`.
  - Any other ID, or a not-taken branch, has no effect.
  - ID 23 additionally pulses `lnk_valid` with `lnk_addr = br_pc + 1`.
- FETCH:
  - `imem_req` = 1 and `imem_addr` = pc.
  - On `imem_ack`: capture `if_ir` = `imem_rdata` and `if_pc` = pc, set pc = pc + 1, go to PRESENT.
  - If the drop flag is set, discard the data instead: clear the flag, stay in FETCH, and request the current pc.
- PRESENT:
  - `if_valid` = 1 and `imem_req` = 0.
  - On `if_ready`, go to FETCH.
- Redirect in PRESENT: `if_valid` drops, pc = target, go to FETCH. Redirect wins over a simultaneous `if_ready`; the presented instruction counts as killed.
- Redirect in FETCH without `imem_ack`: the request is held, since the address must stay stable. pc = target and the drop flag is set.
- Redirect in FETCH coinciding with `imem_ack`: the data is discarded and pc = target.
- `br_warn` with `br_valid`:
  - Go to HALT; no redirect and no link pulse.
  - Any outstanding request runs to `imem_ack`, which is then discarded.
  - HALT holds `imem_req` = 0, `if_valid` = 0, `halted` = 1.
  - The only exit is reset.

## Timing
- Reset values: pc = RESET_PC, state FETCH, `imem_req` = 0, `if_valid` = 0, `if_pc` = 0, `if_ir` = 0, `lnk_valid` = 0, `halted` = 0, drop flag = 0.
- `imem_req` rises one cycle after the first edge with `reset` high.
- Ack on edge N: `if_valid` is high from cycle N+1.
- Accept (`if_valid` & `if_ready`) on edge M: next `imem_req` is high from cycle M+1. Back-to-back throughput is one instruction per 2 cycles plus memory latency.
- `br_valid` on edge K:
  - `imem_addr` = target from K+1, unless a request is held, in which case it applies after that request's ack.
  - `lnk_valid` is high for exactly cycle K+1.
- `reset` low mid-handshake: all state returns to reset values at that edge; a late `imem_ack` arriving with `imem_req` = 0 is ignored.

## Structure
- Shared package `cse_bubble_pkg`:
  - instruction-ID constants (`ID_BEQ`=15 … `ID_JAL`=23)
  - fetch state enum
- Sub-module `branch_resolve` (combinational): (`br_id`, `br_pc`, `br_out`) → `taken`, `target`, `is_link`. The FSM stays in `fetch_unit`.

## Test plan
- Reset release, memory acks 1 cycle after req, `if_ready` tied high → fetch addresses 0, 1, 2, 3; `if_pc` matches each.
- PRESENT at pc 5, `br_valid`, ID 16, `br_pc` = 5, `br_out` = 2, `if_ready` high same cycle → instruction killed, next `imem_addr` = 8.
- FETCH held at addr 9 with ack delayed 3 cycles, redirect ID 21, `br_out` = 100 → ack data at addr 9 discarded, next request addr 100.
- ID 23, `br_pc` = 40, `br_out` = 100 → `lnk_valid` pulse with `lnk_addr` = 41; next fetch 100. ID 15 with `br_out` = 0 → no redirect.
- `br_warn` high with request outstanding → ack consumed, `halted` = 1, no further `imem_req`; assert `reset` low → pc = RESET_PC, fetch resumes at 0.
- Decode stalls (`if_ready` low for 5 cycles) → `if_valid`, `if_pc`, `if_ir` stable, `imem_req` = 0 throughout.
